// File: rtl/fetch_sequencer_pkg.sv
// Shared definitions for the fetch sequencer: instruction field positions,
// opcode encodings and the sequencer FSM states.
package fetch_sequencer_pkg;

    localparam int INSTR_W = 28;

    // Instruction field bit positions
    localparam int OP_MSB   = 27;
    localparam int OP_LSB   = 24;
    localparam int TGT_MSB  = 23;
    localparam int TGT_LSB  = 16;
    localparam int SRC1_MSB = 15;
    localparam int SRC1_LSB = 8;
    localparam int SRC0_MSB = 7;
    localparam int SRC0_LSB = 0;

    // Opcode encodings; anything not listed executes as a sequential instruction
    typedef enum logic [3:0] {
        OP_NOP  = 4'h0,
        OP_STO  = 4'h1,
        OP_ADD  = 4'h2,
        OP_SHL  = 4'h3,
        OP_JMP  = 4'h8,
        OP_CALL = 4'h9,
        OP_RET  = 4'hA,
        OP_BLE  = 4'hB
    } opcode_e;

    typedef enum logic [1:0] {
        ST_START = 2'd0,
        ST_RUN   = 2'd1,
        ST_HALT  = 2'd2
    } state_e;

endpackage

// File: rtl/fetch_sequencer_return_stack.sv
// Hardware return-address LIFO. Push writes stack[sp] then increments sp;
// pop presents stack[sp-1] combinationally and decrements sp.
module return_stack #(
    parameter int STACK_DEPTH = 4,
    parameter int ADDR_W      = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic              pop,
    input  logic [ADDR_W-1:0] data_in,
    output logic [ADDR_W-1:0] data_out,
    output logic              full,
    output logic              empty
);

    localparam int IDX_W = $clog2(STACK_DEPTH);
    localparam int SP_W  = IDX_W + 1;

    logic [SP_W-1:0]   sp;
    logic [IDX_W-1:0]  top_idx;
    logic [ADDR_W-1:0] mem [STACK_DEPTH];

    assign full     = (sp == SP_W'(STACK_DEPTH));
    assign empty    = (sp == '0);
    assign top_idx  = IDX_W'(sp - SP_W'(1));
    assign data_out = mem[top_idx];

    // Stack pointer: guarded so an illegal push/pop can never corrupt it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sp <= '0;
        end else if (push && !full) begin
            // NOTE: state updates use non-blocking assignments so every register samples pre-edge values.
            sp <= sp + SP_W'(1);
        end else if (pop && !empty) begin
            sp <= sp - SP_W'(1);
        end
    end

    // Entry storage
    // NOTE: the storage array is deliberately not reset; sp alone defines which entries are live.
    always_ff @(posedge clk) begin
        if (push && !full) begin
            mem[sp[IDX_W-1:0]] <= data_in;
        end
    end

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction fetch and control-flow unit: owns PC, IR and the return stack,
// resolves JMP/CALL/RET/BLE without bubbles and halts on stack misuse.
module fetch_sequencer
    import fetch_sequencer_pkg::*;
#(
    parameter int STACK_DEPTH = 4,
    parameter int ADDR_W      = 16
) (
    input  logic               Clock,
    input  logic               Reset,
    output logic [ADDR_W-1:0]  oAddress,
    input  logic [INSTR_W-1:0] iInstruction,
    input  logic               iBranchTaken,
    input  logic               iStall,
    output logic [INSTR_W-1:0] oInstruction,
    output logic               oValid,
    output logic               oStackOverflow,
    output logic               oStackUnderflow,
    output logic               oHalted
);

    state_e             state, state_next;
    logic [ADDR_W-1:0]  pc, pc_next, pc_inc, target;
    logic [INSTR_W-1:0] ir, ir_next;
    logic               valid, valid_next;
    logic               overflow, overflow_next;
    logic               underflow, underflow_next;
    logic               push, pop;
    logic [ADDR_W-1:0]  stack_top;
    logic               stack_full, stack_empty;
    logic [3:0]         op;

    assign op     = iInstruction[OP_MSB:OP_LSB];
    assign target = {{(ADDR_W-8){1'b0}}, iInstruction[TGT_MSB:TGT_LSB]};
    assign pc_inc = pc + ADDR_W'(1);

    return_stack #(
        .STACK_DEPTH(STACK_DEPTH),
        .ADDR_W     (ADDR_W)
    ) u_stack (
        .clk     (Clock),
        .rst_n   (Reset),
        .push    (push),
        .pop     (pop),
        .data_in (pc_inc),
        .data_out(stack_top),
        .full    (stack_full),
        .empty   (stack_empty)
    );

    // FSM state register
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state <= ST_START;
        end else begin
            state <= state_next;
        end
    end

    // Next-state, next-PC and accept decode
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        state_next     = state;
        pc_next        = pc;
        ir_next        = ir;
        valid_next     = 1'b0;
        overflow_next  = overflow;
        underflow_next = underflow;
        push           = 1'b0;
        pop            = 1'b0;

        case (state)
            ST_START: begin
                state_next = ST_RUN;
            end
            ST_RUN: begin
                if (!iStall) begin
                    ir_next    = iInstruction;
                    valid_next = 1'b1;
                    pc_next    = pc_inc;
                    case (op)
                        OP_JMP: begin
                            pc_next = target;
                        end
                        OP_CALL: begin
                            if (stack_full) begin
                                pc_next       = pc;
                                overflow_next = 1'b1;
                                state_next    = ST_HALT;
                            end else begin
                                push    = 1'b1;
                                pc_next = target;
                            end
                        end
                        OP_RET: begin
                            if (stack_empty) begin
                                pc_next        = pc;
                                underflow_next = 1'b1;
                                state_next     = ST_HALT;
                            end else begin
                                pop     = 1'b1;
                                pc_next = stack_top;
                            end
                        end
                        OP_BLE: begin
                            if (iBranchTaken) begin
                                pc_next = target;
                            end
                        end
                        default: begin
                        end
                    endcase
                end
            end
            ST_HALT: begin
            end
            default: begin
                state_next = ST_START;
            end
        endcase
    end

    // PC, IR, valid strobe and sticky error flags
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            pc        <= '0;
            ir        <= {OP_NOP, 24'b0};
            valid     <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            pc        <= pc_next;
            ir        <= ir_next;
            valid     <= valid_next;
            overflow  <= overflow_next;
            underflow <= underflow_next;
        end
    end

    assign oAddress        = pc;
    assign oInstruction    = ir;
    assign oValid          = valid;
    assign oStackOverflow  = overflow;
    assign oStackUnderflow = underflow;
    assign oHalted         = (state == ST_HALT);

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed self-checking bench for fetch_sequencer with a combinational ROM model.
module tb_fetch_sequencer;
    import fetch_sequencer_pkg::*;

    localparam int ADDR_W      = 16;
    localparam int STACK_DEPTH = 4;

    logic              Clock = 1'b0;
    logic              Reset = 1'b0;
    logic [ADDR_W-1:0] oAddress;
    logic [27:0]       iInstruction;
    logic              iBranchTaken = 1'b0;
    logic              iStall = 1'b0;
    logic [27:0]       oInstruction;
    logic              oValid;
    logic              oStackOverflow;
    logic              oStackUnderflow;
    logic              oHalted;

    logic [27:0] rom [0:65535];

    int n_checks = 0;
    int n_fail   = 0;

    fetch_sequencer #(
        .STACK_DEPTH(STACK_DEPTH),
        .ADDR_W     (ADDR_W)
    ) dut (
        .Clock          (Clock),
        .Reset          (Reset),
        .oAddress       (oAddress),
        .iInstruction   (iInstruction),
        .iBranchTaken   (iBranchTaken),
        .iStall         (iStall),
        .oInstruction   (oInstruction),
        .oValid         (oValid),
        .oStackOverflow (oStackOverflow),
        .oStackUnderflow(oStackUnderflow),
        .oHalted        (oHalted)
    );

    always #5 Clock = ~Clock;

    assign iInstruction = rom[oAddress];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [27:0] ins(input logic [3:0] op, input logic [7:0] tgt);
        return {op, tgt, 16'h0000};
    endfunction

    task automatic clear_rom();
        for (int i = 0; i < 65536; i++) rom[i] = ins(OP_NOP, 8'h00);
    endtask

    // Advance one clock; outputs are sampled on the falling edge
    task automatic step();
        @(posedge Clock);
        @(negedge Clock);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_addr"},  32'(oAddress), 32'h0);
        check({tag, "_valid"}, 32'(oValid), 32'h0);
        check({tag, "_ir"},    32'(oInstruction), 32'(ins(OP_NOP, 8'h00)));
        check({tag, "_ovf"},   32'(oStackOverflow), 32'h0);
        check({tag, "_unf"},   32'(oStackUnderflow), 32'h0);
        check({tag, "_halt"},  32'(oHalted), 32'h0);
    endtask

    // Hold reset across a falling edge, check reset outputs, release on a falling edge
    task automatic do_reset(input string tag);
        iStall       = 1'b0;
        iBranchTaken = 1'b0;
        Reset        = 1'b0;
        @(negedge Clock);
        check_reset_values(tag);
        @(negedge Clock);
        Reset = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [ADDR_W-1:0] exp_addr [17];
        logic [ADDR_W-1:0] prev;
        int ble_seen;

        // ---------- free run, subroutine, BLE loop ----------
        clear_rom();
        rom[1]  = ins(OP_STO, 8'h00);
        rom[2]  = ins(OP_STO, 8'h00);
        rom[3]  = ins(OP_STO, 8'h00);
        rom[4]  = ins(OP_CALL, 8'd7);
        rom[5]  = ins(OP_ADD, 8'h00);
        rom[6]  = ins(OP_JMP, 8'd9);
        rom[7]  = ins(OP_SHL, 8'h00);
        rom[8]  = ins(OP_RET, 8'h00);
        rom[9]  = ins(OP_ADD, 8'h00);
        rom[11] = ins(OP_BLE, 8'd10);
        exp_addr = '{16'd0, 16'd1, 16'd2, 16'd3, 16'd4, 16'd7, 16'd8, 16'd5, 16'd6,
                     16'd9, 16'd10, 16'd11, 16'd10, 16'd11, 16'd10, 16'd11, 16'd12};
        do_reset("rst0");
        check("start_addr", 32'(oAddress), 32'h0);
        ble_seen = 0;
        for (int i = 0; i < 17; i++) begin
            prev = oAddress;
            if (oAddress == 16'd11) begin
                iBranchTaken = (ble_seen < 2);
                ble_seen++;
            end else begin
                iBranchTaken = 1'b0;
            end
            step();
            check($sformatf("seq_addr[%0d]", i), 32'(oAddress), 32'(exp_addr[i]));
            if (i == 0) begin
                check("seq_valid_start", 32'(oValid), 32'h0);
            end else begin
                check($sformatf("seq_valid[%0d]", i), 32'(oValid), 32'h1);
                check($sformatf("seq_ir[%0d]", i), 32'(oInstruction), 32'(rom[prev]));
            end
        end
        check("seq_ovf", 32'(oStackOverflow), 32'h0);
        check("seq_unf", 32'(oStackUnderflow), 32'h0);
        check("seq_halt", 32'(oHalted), 32'h0);

        // ---------- nested CALLs: four legal, fifth overflows ----------
        clear_rom();
        for (int k = 0; k < 5; k++) rom[k] = ins(OP_CALL, 8'(k + 1));
        do_reset("rst1");
        step();
        check("ovf_start_valid", 32'(oValid), 32'h0);
        for (int k = 1; k <= 4; k++) begin
            step();
            check($sformatf("ovf_call_addr[%0d]", k), 32'(oAddress), 32'(k));
            check($sformatf("ovf_call_flag[%0d]", k), 32'(oStackOverflow), 32'h0);
        end
        step();
        check("ovf_fifth_valid", 32'(oValid), 32'h1);
        check("ovf_fifth_ir",    32'(oInstruction), 32'(ins(OP_CALL, 8'd5)));
        check("ovf_fifth_addr",  32'(oAddress), 32'h4);
        check("ovf_flag",        32'(oStackOverflow), 32'h1);
        check("ovf_halted",      32'(oHalted), 32'h1);
        check("ovf_unf_clear",   32'(oStackUnderflow), 32'h0);
        for (int k = 0; k < 2; k++) begin
            step();
            check($sformatf("ovf_hold_valid[%0d]", k), 32'(oValid), 32'h0);
            check($sformatf("ovf_hold_addr[%0d]", k), 32'(oAddress), 32'h4);
            check($sformatf("ovf_hold_halt[%0d]", k), 32'(oHalted), 32'h1);
        end

        // ---------- RET on empty stack, then async reset in HALT ----------
        clear_rom();
        rom[0] = ins(OP_RET, 8'h00);
        do_reset("rst2");
        step();
        step();
        check("unf_valid", 32'(oValid), 32'h1);
        check("unf_ir",    32'(oInstruction), 32'(ins(OP_RET, 8'h00)));
        check("unf_addr",  32'(oAddress), 32'h0);
        check("unf_flag",  32'(oStackUnderflow), 32'h1);
        check("unf_halt",  32'(oHalted), 32'h1);
        step();
        check("unf_hold_valid", 32'(oValid), 32'h0);
        @(posedge Clock);
        #2 Reset = 1'b0;
        #1 check_reset_values("async_rst");
        rom[0] = ins(OP_NOP, 8'h00);
        @(negedge Clock);
        Reset = 1'b1;
        step();
        check("restart_start_addr",  32'(oAddress), 32'h0);
        check("restart_start_valid", 32'(oValid), 32'h0);
        step();
        check("restart_addr",  32'(oAddress), 32'h1);
        check("restart_valid", 32'(oValid), 32'h1);

        // ---------- stall holding a CALL; exactly one push on release ----------
        clear_rom();
        rom[0]     = ins(OP_CALL, 8'h20);
        rom[16'h20] = ins(OP_RET, 8'h00);
        rom[1]     = ins(OP_RET, 8'h00);
        do_reset("rst3");
        iStall = 1'b1;
        step();
        check("stall_start_addr", 32'(oAddress), 32'h0);
        for (int k = 0; k < 3; k++) begin
            step();
            check($sformatf("stall_addr[%0d]", k),  32'(oAddress), 32'h0);
            check($sformatf("stall_valid[%0d]", k), 32'(oValid), 32'h0);
            check($sformatf("stall_ir[%0d]", k),    32'(oInstruction), 32'(ins(OP_NOP, 8'h00)));
        end
        iStall = 1'b0;
        step();
        check("stall_rel_addr",  32'(oAddress), 32'h20);
        check("stall_rel_valid", 32'(oValid), 32'h1);
        check("stall_rel_ir",    32'(oInstruction), 32'(ins(OP_CALL, 8'h20)));
        step();
        check("stall_ret_addr", 32'(oAddress), 32'h1);
        check("stall_ret_unf",  32'(oStackUnderflow), 32'h0);
        step();
        check("stall_second_ret_unf",  32'(oStackUnderflow), 32'h1);
        check("stall_second_ret_halt", 32'(oHalted), 32'h1);
        check("stall_second_ret_addr", 32'(oAddress), 32'h1);

        // ---------- PC wrap from 16'hFFFF to 0 ----------
        clear_rom();
        do_reset("rst4");
        step();
        repeat (65535) step();
        check("wrap_top_addr", 32'(oAddress), 32'hFFFF);
        step();
        check("wrap_addr",  32'(oAddress), 32'h0);
        check("wrap_valid", 32'(oValid), 32'h1);
        check("wrap_halt",  32'(oHalted), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
